// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - Fetch-address generator with request handshake, prioritised redirects and stall support
//
// Purpose:
//   Produces the instruction-fetch address stream for the core. A request is
//   presented with req_valid_o/pc_o and held until req_ready_i accepts it.
//   Redirect sources override sequential flow; a redirect that arrives while
//   a request is outstanding is parked in a one-entry pending buffer and
//   applied when the request is accepted.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous reset, active-high
//   redir_en_i     per-source redirect request (index 0 = highest priority)
//   redir_addr_i   packed redirect targets, source k at [k*ADDR_W +: ADDR_W]
//   stall_i        hold request from pipeline control
//   req_valid_o    fetch request valid
//   req_ready_i    instruction memory accepts the request
//   pc_o           fetch address of the current request
//   redir_taken_o  high in the cycle pc_o first shows a redirect/pending target
//   misalign_o     sticky misaligned-target flag (only with PC_MISALIGN_CHK_EN)
//
// Build option:
//   PC_MISALIGN_CHK_EN - when defined, loaded targets have their low
//   log2(INST_BYTES) bits cleared and misalign_o reports whether the most
//   recent loaded target was misaligned.

module pc_gen #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                INST_BYTES = 4,
    parameter int                NUM_REDIR  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REDIR-1:0]        redir_en_i,
    input  logic [NUM_REDIR*ADDR_W-1:0] redir_addr_i,
    input  logic                        stall_i,
    output logic                        req_valid_o,
    input  logic                        req_ready_i,
    output logic [ADDR_W-1:0]           pc_o,
    output logic                        redir_taken_o
`ifdef PC_MISALIGN_CHK_EN
    ,
    output logic                        misalign_o
`endif
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    localparam logic [ADDR_W-1:0] INST_STEP = ADDR_W'(INST_BYTES);

`ifdef PC_MISALIGN_CHK_EN
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INST_BYTES - 1));
`endif

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              taken_q, taken_d;
`ifdef PC_MISALIGN_CHK_EN
    logic              misalign_q, misalign_d;
`endif

    logic              win_vld;
    logic [ADDR_W-1:0] win_addr;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;

    // Priority select: scan from the highest index down so the lowest
    // asserted index is the last assignment and therefore wins.
    always_comb begin
        win_vld  = 1'b0;
        win_addr = '0;
        for (int k = NUM_REDIR - 1; k >= 0; k--) begin
            if (redir_en_i[k]) begin
                win_vld  = 1'b1;
                win_addr = redir_addr_i[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // Next-state logic. load_en/load_addr describe a redirect-style load of
    // pc; sequential advance writes pc_d directly.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        taken_d     = 1'b0;
        load_en     = 1'b0;
        load_addr   = win_addr;

        case (state_q)
            ST_BOOT: begin
                // Nothing outstanding yet, so a redirect goes straight to pc.
                state_d = ST_FETCH;
                load_en = win_vld;
            end

            ST_FETCH: begin
                if (req_ready_i) begin
                    pend_vld_d = 1'b0;
                    state_d    = stall_i ? ST_STALL : ST_FETCH;
                    if (win_vld) begin
                        load_en = 1'b1;
                    end else if (pend_vld_q) begin
                        load_en   = 1'b1;
                        load_addr = pend_addr_q;
                    end else begin
                        pc_d = pc_q + INST_STEP;
                    end
                end else if (win_vld) begin
                    // pc must stay stable under an outstanding request; park
                    // the newest redirect (older pending entries are stale).
                    pend_vld_d  = 1'b1;
                    pend_addr_d = win_addr;
                end
            end

            ST_STALL: begin
                // No request is outstanding, so the redirect loads directly.
                load_en = win_vld;
                if (!stall_i) begin
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase

`ifdef PC_MISALIGN_CHK_EN
        misalign_d = misalign_q;
        if (load_en) begin
            pc_d       = load_addr & ALIGN_MASK;
            taken_d    = 1'b1;
            misalign_d = |(load_addr & ~ALIGN_MASK);
        end
`else
        if (load_en) begin
            pc_d    = load_addr;
            taken_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            taken_q     <= 1'b0;
`ifdef PC_MISALIGN_CHK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            taken_q     <= taken_d;
`ifdef PC_MISALIGN_CHK_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign req_valid_o   = (state_q == ST_FETCH);
    assign pc_o          = pc_q;
    assign redir_taken_o = taken_q;
`ifdef PC_MISALIGN_CHK_EN
    assign misalign_o    = misalign_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - Self-checking bench for pc_gen: directed scenarios plus randomized stimulus against a reference model

module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  redir_en_i;
    logic [63:0] redir_addr_i;
    logic        stall_i;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [31:0] pc_o;
    logic        redir_taken_o;
`ifdef PC_MISALIGN_CHK_EN
    logic        misalign_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_gen #(
        .ADDR_W(32),
        .RESET_PC(32'h0),
        .INST_BYTES(4),
        .NUM_REDIR(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .redir_en_i(redir_en_i),
        .redir_addr_i(redir_addr_i),
        .stall_i(stall_i),
        .req_valid_o(req_valid_o),
        .req_ready_i(req_ready_i),
        .pc_o(pc_o),
        .redir_taken_o(redir_taken_o)
`ifdef PC_MISALIGN_CHK_EN
        ,
        .misalign_o(misalign_o)
`endif
    );

    // Reference model: "booting" / "holding" flags describe the phase of
    // the generator, a queue holds at most one parked redirect target.
    logic [31:0] m_pc;
    bit          m_booting;
    bit          m_holding;
    logic [31:0] m_parked[$];
    bit          m_taken;
    bit          m_mis;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_load(input logic [31:0] t);
        logic [31:0] v;
        v = t;
`ifdef PC_MISALIGN_CHK_EN
        m_mis = (t % 4) != 0;
        v = t - (t % 4);
`endif
        m_pc    = v;
        m_taken = 1'b1;
    endtask

    task automatic m_advance(input bit r, input logic [1:0] en, input logic [31:0] a0,
                             input logic [31:0] a1, input bit st, input bit rd);
        bit          have;
        logic [31:0] win;
        if (r) begin
            m_pc      = 32'h0;
            m_booting = 1'b1;
            m_holding = 1'b0;
            m_parked.delete();
            m_taken   = 1'b0;
            m_mis     = 1'b0;
            return;
        end
        have    = en[0] || en[1];
        win     = en[0] ? a0 : a1;
        m_taken = 1'b0;
        if (m_booting) begin
            m_booting = 1'b0;
            if (have) m_load(win);
        end else if (m_holding) begin
            if (have) m_load(win);
            if (!st) m_holding = 1'b0;
        end else if (rd) begin
            if (have) m_load(win);
            else if (m_parked.size() > 0) m_load(m_parked[0]);
            else m_pc = 32'(m_pc + 32'd4);
            m_parked.delete();
            m_holding = st;
        end else if (have) begin
            m_parked.delete();
            m_parked.push_back(win);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input bit r, input logic [1:0] en, input logic [31:0] a0,
                        input logic [31:0] a1, input bit st, input bit rd);
        rst          = r;
        redir_en_i   = en;
        redir_addr_i = {a1, a0};
        stall_i      = st;
        req_ready_i  = rd;
        m_advance(r, en, a0, a1, st, rd);
        @(posedge clk);
        @(negedge clk);
        check("pc", 64'(pc_o), 64'(m_pc));
        check("valid", 64'(req_valid_o), 64'(!m_booting && !m_holding));
        check("taken", 64'(redir_taken_o), 64'(m_taken));
`ifdef PC_MISALIGN_CHK_EN
        check("misalign", 64'(misalign_o), 64'(m_mis));
`endif
    endtask

    initial begin
        logic [1:0]  ren;
        logic [31:0] ra0, ra1;
        rst = 1'b1; redir_en_i = '0; redir_addr_i = '0; stall_i = 1'b0; req_ready_i = 1'b0;
        m_pc = 32'h0; m_booting = 1'b1; m_holding = 1'b0; m_taken = 1'b0; m_mis = 1'b0;
        @(negedge clk);

        // Reset state
        step(1, 2'b00, 0, 0, 0, 1);
        check("rst_pc", 64'(pc_o), 64'h0);
        check("rst_valid", 64'(req_valid_o), 64'h0);
        check("rst_taken", 64'(redir_taken_o), 64'h0);

        // Sequential fetch with ready held high
        step(0, 2'b00, 0, 0, 0, 1);
        check("seq_boot_exit", 64'({req_valid_o, pc_o}), {31'h0, 1'b1, 32'h0});
        step(0, 2'b00, 0, 0, 0, 1);
        check("seq_4", 64'(pc_o), 64'h4);
        step(0, 2'b00, 0, 0, 0, 1);
        check("seq_8", 64'(pc_o), 64'h8);
        step(0, 2'b00, 0, 0, 0, 1);
        check("seq_c", 64'(pc_o), 64'hC);
        step(0, 2'b00, 0, 0, 0, 1);
        check("seq_10", 64'(pc_o), 64'h10);

        // Back-pressure with a redirect parked mid-wait
        step(0, 2'b00, 0, 0, 0, 0);
        check("hold_1", 64'(pc_o), 64'h10);
        step(0, 2'b10, 0, 32'h200, 0, 0);
        check("hold_2", 64'(pc_o), 64'h10);
        check("hold_2_taken", 64'(redir_taken_o), 64'h0);
        step(0, 2'b00, 0, 0, 1, 0);
        check("hold_3_stall_ignored", 64'({req_valid_o, pc_o}), {31'h0, 1'b1, 32'h10});
        step(0, 2'b00, 0, 0, 0, 1);
        check("pend_load", 64'(pc_o), 64'h200);
        check("pend_taken", 64'(redir_taken_o), 64'h1);
        step(0, 2'b00, 0, 0, 0, 0);
        check("pend_taken_once", 64'(redir_taken_o), 64'h0);

        // Simultaneous redirects at accept: index 0 wins
        step(0, 2'b11, 32'h80, 32'h400, 0, 1);
        check("prio", 64'(pc_o), 64'h80);

        // Fresh redirect beats pending; pending then discarded
        step(0, 2'b10, 0, 32'h400, 0, 0);
        step(0, 2'b01, 32'h900, 0, 0, 1);
        check("new_beats_pend", 64'(pc_o), 64'h900);
        step(0, 2'b00, 0, 0, 0, 1);
        check("pend_discarded", 64'(pc_o), 64'h904);

        // Stall at accept
        step(0, 2'b00, 0, 0, 1, 1);
        check("stall_enter", 64'({req_valid_o, pc_o}), {31'h0, 1'b0, 32'h908});
        step(0, 2'b00, 0, 0, 1, 1);
        check("stall_hold", 64'({req_valid_o, pc_o}), {31'h0, 1'b0, 32'h908});
        step(0, 2'b00, 0, 0, 0, 1);
        check("stall_exit", 64'({req_valid_o, pc_o}), {31'h0, 1'b1, 32'h908});

        // Address wrap
        step(0, 2'b01, 32'hFFFF_FFFC, 0, 0, 1);
        step(0, 2'b00, 0, 0, 0, 1);
        check("wrap", 64'(pc_o), 64'h0);

        // Reset with a pending redirect, and reset mid-stall
        step(0, 2'b01, 32'h300, 0, 0, 0);
        step(1, 2'b00, 0, 0, 0, 1);
        check("rst_pend", 64'({redir_taken_o, req_valid_o, pc_o}), 64'h0);
        step(0, 2'b00, 0, 0, 0, 1);
        step(0, 2'b00, 0, 0, 1, 1);
        step(1, 2'b01, 32'h700, 0, 1, 1);
        check("rst_stall", 64'({redir_taken_o, req_valid_o, pc_o}), 64'h0);
        step(0, 2'b00, 0, 0, 0, 1);
        check("rst_pend_gone", 64'(pc_o), 64'h0);

`ifdef PC_MISALIGN_CHK_EN
        step(0, 2'b01, 32'h102, 0, 0, 1);
        check("mis_set", 64'({misalign_o, pc_o}), {31'h0, 1'b1, 32'h100});
        step(0, 2'b00, 0, 0, 0, 1);
        check("mis_sticky", 64'(misalign_o), 64'h1);
        step(0, 2'b01, 32'h200, 0, 0, 1);
        check("mis_clear", 64'({misalign_o, pc_o}), {31'h0, 1'b0, 32'h200});
`endif

        // Randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            ren = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ra0 = $urandom;
            ra1 = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                ra0 = ra0 & 32'hFFFF_FFFC;
                ra1 = ra1 & 32'hFFFF_FFFC;
            end
            step($urandom_range(0, 99) == 0, ren, ra0, ra1,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised fetch-address generator; successor to the free-running PC register.
- Adds the following over the free-running PC:
  - a valid/ready fetch-request handshake toward instruction memory,
  - N prioritised redirect sources (trap, jump, ...),
  - a pending-redirect buffer and stall support.
- Sits between the control/trap logic and the instruction-fetch interface of the core.

Parameters:
- ADDR_W, 32, PC and redirect address width in bits.
- RESET_PC, 32'h0000_0000, first fetch address after reset (ADDR_W bits used).
- INST_BYTES, 4, sequential PC increment in bytes; power of two, 2 or 4.
- NUM_REDIR, 2, number of redirect sources; index 0 has highest priority.

Ports:
- clk  in  1  Clock; all state updates on rising edge.
- rst  in  1  Synchronous reset, active-high.
- redir_en_i  in  NUM_REDIR  Per-source redirect request, single-cycle pulses.
- redir_addr_i  in  NUM_REDIR*ADDR_W  Packed redirect targets; source k occupies bits [k*ADDR_W +: ADDR_W].
- stall_i  in  1  Hold request from pipeline control.
- req_valid_o  out  1  Fetch request valid.
- req_ready_i  in  1  Instruction memory accepts request.
- pc_o  out  ADDR_W  Fetch address of the current request.
- redir_taken_o  out  1  One-cycle pulse: a redirect target was loaded into pc_o this cycle (registered).
- misalign_o  out  1  Present only with PC_MISALIGN_CHK_EN (see Optional Feature).

Behaviour:
- Reset: one clock, synchronous, active-high (rst=1 sampled at posedge).
  - Outputs: pc_o=RESET_PC, req_valid_o=0, redir_taken_o=0.
  - Internal: pending cleared, state=BOOT.
  - rst dominates every other input, including mid-handshake and a pending redirect.
- State BOOT:
  - req_valid_o=0.
  - Next cycle always goes to FETCH; pc_o stays RESET_PC.
  - Redirects in BOOT are loaded directly into pc_o and pulse redir_taken_o.
- State FETCH:
  - req_valid_o=1.
  - pc_o is stable while req_valid_o=1 and req_ready_i=0.
- Accept (req_valid_o & req_ready_i) in FETCH:
  - pc_o <= first of: current-cycle redirect winner, else pending addr, else pc_o+INST_BYTES.
  - pending cleared.
  - Next state: STALL if stall_i=1, else FETCH.
- No accept in FETCH, redirect asserted:
  - Winner written to pending (pend_vld=1, pend_addr); overwrites any older pending.
  - pc_o unchanged; state unchanged.
- State STALL:
  - req_valid_o=0; pc_o holds the already-computed next address.
  - A redirect in STALL loads pc_o directly and pulses redir_taken_o.
  - Leaves to FETCH in the cycle after stall_i is sampled 0.
- stall_i in FETCH without accept: ignored; the outstanding request must complete first.
- Priority: among simultaneous redir_en_i bits, the lowest index wins. Current-cycle redirect beats pending.
- redir_taken_o pulses in the cycle after pc_o takes a redirect or pending target.
- Arithmetic: pc_o+INST_BYTES is modulo 2^ADDR_W; all-ones-aligned top address wraps to 0.
- Latency: redirect sampled at an accept edge produces the target on pc_o on the very next cycle (1 cycle).

Optional Feature:
- Macro: PC_MISALIGN_CHK_EN.
- Defined:
  - Any loaded redirect target whose low log2(INST_BYTES) bits are nonzero sets misalign_o=1, sticky.
  - The target is still loaded with its low bits forced to 0.
  - misalign_o clears on rst or on the next aligned redirect load.
  - Reset value of misalign_o is 0.
- Undefined: misalign_o port absent; targets are loaded unmodified.

Test Plan:
- Reset then ready=1 constant, no redirects -> valid=0 one cycle, then pc_o 0x0,0x4,0x8,0xC on consecutive cycles.
- ready=0 for 3 cycles at pc 0x10 with redir_en_i[1]=1, addr 0x200 in cycle 2 -> pc_o held 0x10; on accept next pc_o=0x200 and redir_taken_o pulses once.
- Same cycle redir_en_i=2'b11, addr0=0x80, addr1=0x400 at accept -> pc_o=0x80.
- Pending 0x400 plus new redirect[0] 0x900 in the accept cycle -> pc_o=0x900, pending discarded. Also: stall_i=1 at accept -> valid=0 until stall drops, pc_o holds next value.
- pc_o=0xFFFF_FFFC, accept, no redirect -> pc_o=0x0. Also: rst=1 mid-stall with pending set -> pc_o=RESET_PC, valid=0, no redir_taken_o pulse.
- With PC_MISALIGN_CHK_EN: redirect to 0x102 -> pc_o=0x100, misalign_o=1; later redirect to 0x200 -> misalign_o=0.
